// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type, command bytes and parity helper for the
// PS/2 host transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_REL,
    DONE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET        = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_DEFAULTS = 8'hF6;
  localparam logic [7:0] PS2_CMD_ENABLE       = 8'hF4;

  // PS/2 parity is odd: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchroniser for one open-drain PS/2 pad plus a one-cycle
// falling-edge strobe. Define PS2_TX_FILTER_EN to add a glitch filter that
// only commits a new level after FILT_LEN consecutive equal samples.
import ps2_pkg::*;

module ps2_line_sync #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  output logic lvl_o,
  output logic fall_o
);

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("ps2_line_sync: FILT_LEN must be >= 1");
  end

  logic [1:0] sync_q;
  logic       lvl;
  logic       prev_q;

  // Two-flop synchroniser; the bus idles high so reset to 1 (no false edge).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], pad_i};
  end

`ifdef PS2_TX_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] fcnt_q;
  logic          filt_q;

  // Count consecutive samples disagreeing with the filtered level; adopt
  // the new level on the FILT_LEN-th one, any agreeing sample restarts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt_q <= '0;
      filt_q <= 1'b1;
    end else if (sync_q[1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FW'(FILT_LEN - 1)) begin
      filt_q <= sync_q[1];
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  // Remember last cycle's level for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b1;
    else         prev_q <= lvl;
  end

  assign lvl_o  = lvl;
  assign fall_o = prev_q & ~lvl;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter. Inhibits the bus,
// issues a request-to-send, shifts out {stop, odd parity, byte} on device
// clock falls, then checks the device ACK with an overall timeout.
// Optional glitch filter on CLK/DATA: define PS2_TX_FILTER_EN.
import ps2_pkg::*;

module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       tx_vld,
  input  logic [7:0] tx_data,
  output logic       tx_rdy,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  ps2_tx_state_t state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          err_q, err_d;

  logic clk_lvl, clk_fall, data_lvl;
  logic data_fall_unused;  // DATA edges are never needed, only its level

  ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_clk_sync (
    .clk_i  (clk_sys),
    .rst_ni (rst_n),
    .pad_i  (ps2_clk_in),
    .lvl_o  (clk_lvl),
    .fall_o (clk_fall)
  );

  ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_data_sync (
    .clk_i  (clk_sys),
    .rst_ni (rst_n),
    .pad_i  (ps2_data_in),
    .lvl_o  (data_lvl),
    .fall_o (data_fall_unused)
  );

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state and line/handshake decode. sh_q[0] is the bit on the wire
  // while in SEND; each device clock fall shifts the next one in.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    err_d       = err_q;
    tx_rdy      = 1'b0;
    tx_busy     = 1'b1;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;

    case (state_q)
      IDLE: begin
        tx_rdy  = 1'b1;
        tx_busy = 1'b0;
        cyc_d   = '0;
        if (tx_vld) begin
          sh_d    = {1'b1, odd_parity(tx_data), tx_data};
          err_d   = 1'b0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cyc_q == CW'(INHIBIT_CYC - 1)) begin
          ps2_data_oe = 1'b1;  // start bit goes down while CLK is still held
          cyc_d       = '0;
          state_d     = REQ;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      REQ: begin
        ps2_data_oe = 1'b1;
        if (clk_fall) begin
          bit_cnt_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        ps2_data_oe = ~sh_q[0];
        if (clk_fall) begin
          sh_d      = {1'b1, sh_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd8) state_d = ACK;  // this fall presents stop
        end
      end
      ACK: begin
        // stop bit: DATA released so the device can pull it low
        if (clk_fall) begin
          err_d   = data_lvl;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (clk_lvl && data_lvl) state_d = DONE;
      end
      DONE: begin
        tx_done = 1'b1;
        tx_err  = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // One watchdog covers the whole device-clocked part of the transfer.
    if (state_q inside {REQ, SEND, ACK, WAIT_REL}) begin
      cyc_d = cyc_q + 1'b1;
      if (cyc_q == CW'(TIMEOUT_CYC - 1)) begin
        err_d   = 1'b1;
        state_d = DONE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model. A per-cycle
// monitor checks the handshake/line rules derived from the transaction
// timeline; per-transaction checks compare captured frames with literals
// and an arithmetic frame model.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tx_vld  = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_rdy, tx_busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic [9:0] dbits;

  // Open-drain bus: either side can pull low.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk_sys = ~clk_sys;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILT_LEN(4)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .tx_vld      (tx_vld),
    .tx_data     (tx_data),
    .tx_rdy      (tx_rdy),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame as the device should see it: d0..d7, odd parity, stop=1.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d};
  endfunction

  // ---------------- per-cycle monitor / model ----------------
  bit         m_busy   = 1'b0;
  int         k        = 0;   // cycles since accept
  int         cyc      = 0;
  int         req_cyc  = 0;
  int         done_cyc = -10;
  int         done_cnt = 0;
  int         inh_run  = 0;
  int         inh_len  = 0;
  logic       done_err = 1'b0;
  logic [1:0] done_oe  = 2'b00;
  logic       rdy_after_done = 1'b0;

  always @(negedge clk_sys) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      k       = 0;
      inh_run = 0;
    end else begin
      cyc++;
      chk("busy", tx_busy, m_busy);
      chk("rdy", tx_rdy, !m_busy);
      if (!m_busy) begin
        chk("idle_clk_oe", ps2_clk_oe, 0);
        chk("idle_data_oe", ps2_data_oe, 0);
        chk("idle_done", tx_done, 0);
      end else if (k <= INH) begin
        chk("inh_clk_oe", ps2_clk_oe, 1);
        chk("inh_data_oe", ps2_data_oe, (k == INH));
      end else begin
        chk("post_inh_clk_oe", ps2_clk_oe, 0);
        if (k == INH + 1) begin
          chk("req_data_oe", ps2_data_oe, 1);
          req_cyc = cyc;
        end
      end
      if (cyc == done_cyc + 1) rdy_after_done = tx_rdy;
      if (ps2_clk_oe) inh_run++;
      else if (inh_run != 0) begin
        inh_len = inh_run;
        inh_run = 0;
      end
      // advance the model to the next cycle
      if (!m_busy) begin
        if (tx_vld) begin
          m_busy = 1'b1;
          k      = 1;
        end
      end else begin
        k++;
        if (tx_done) begin
          m_busy   = 1'b0;
          done_cnt++;
          done_err = tx_err;
          done_cyc = cyc;
          done_oe  = {ps2_clk_oe, ps2_data_oe};
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    cyc_wait(1);
    tx_vld  = 1'b1;
    tx_data = d;
    cyc_wait(1);
    tx_vld  = 1'b0;
    tx_data = 8'hA5;  // must not leak into the frame
  endtask

  task automatic wait_done(input int start, input int budget);
    int t = 0;
    while (done_cnt == start && t < budget) begin
      @(negedge clk_sys);
      t++;
    end
    if (done_cnt == start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_wait: no tx_done within %0d cycles", budget);
    end
  endtask

  // Device: wait for request-to-send, clock 10 bits sampling on each rise,
  // then the ACK clock. abort_at>0 returns with CLK low after that fall.
  task automatic dev_frame(input bit ack, input int abort_at, output logic [9:0] bits);
    int  t   = 0;
    bit  got = 1'b0;
    bits = '0;
    while (!got && t < INH + 100) begin
      @(negedge clk_sys);
      got = (ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1);
      t++;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_wait: no request-to-send within %0d cycles", INH + 100);
      return;
    end
    cyc_wait(10);
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      if (abort_at == i + 1) return;
      cyc_wait(HALF);
      bits[i] = ps2_data_in;
      dev_clk = 1'b1;
      cyc_wait(HALF);
    end
    dev_data = ack ? 1'b0 : 1'b1;
    cyc_wait(4);
    dev_clk = 1'b0;
    cyc_wait(HALF);
    dev_clk = 1'b1;
    cyc_wait(HALF);
    dev_data = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s;

    // reset state
    cyc_wait(3);
    chk("rst_rdy", tx_rdy, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    cyc_wait(3);

    // 1: 0xF4 with ACK
    s = done_cnt;
    send(8'hF4);
    dev_frame(1'b1, 0, dbits);
    wait_done(s, 500);
    chk("t1_bits", dbits, 10'b10_1111_0100);
    chk("t1_err", done_err, 0);
    chk("t1_inh_len", inh_len, INH);
    chk("t1_ndone", done_cnt - s, 1);

    // 2: 0xFF with ACK, ready again the cycle after done
    s = done_cnt;
    send(8'hFF);
    dev_frame(1'b1, 0, dbits);
    wait_done(s, 500);
    cyc_wait(2);
    chk("t2_bits", dbits, 10'b11_1111_1111);
    chk("t2_err", done_err, 0);
    chk("t2_rdy_after_done", rdy_after_done, 1);

    // 3: device NACKs (DATA left high)
    s = done_cnt;
    send(8'hF6);
    dev_frame(1'b0, 0, dbits);
    wait_done(s, 500);
    chk("t3_bits", dbits, exp_frame(8'hF6));
    chk("t3_err", done_err, 1);
    chk("t3_oe_released", done_oe, 0);

    // 4: device never clocks -> timeout measured from REQ entry
    s = done_cnt;
    send(8'hF4);
    wait_done(s, INH + TMO + 100);
    chk("t4_err", done_err, 1);
    chk("t4_latency", done_cyc - req_cyc, TMO);
    chk("t4_oe_released", done_oe, 0);

    // 5: request while busy is ignored
    s = done_cnt;
    send(8'hF4);
    fork
      dev_frame(1'b1, 0, dbits);
      begin
        cyc_wait(INH + 100);
        tx_vld  = 1'b1;
        tx_data = 8'h00;
        cyc_wait(60);
        tx_vld  = 1'b0;
      end
    join
    wait_done(s, 500);
    cyc_wait(30);
    chk("t5_bits", dbits, 10'b10_1111_0100);
    chk("t5_err", done_err, 0);
    chk("t5_ndone", done_cnt - s, 1);

    // 6: asynchronous reset mid-SEND, then a clean transfer
    send(8'hF4);
    dev_frame(1'b1, 1, dbits);
    cyc_wait(10);
    chk("t6_pre_data_oe", ps2_data_oe, 1);  // d0 of 0xF4 is 0
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_clk_oe", ps2_clk_oe, 0);
    chk("t6_rst_data_oe", ps2_data_oe, 0);
    chk("t6_rst_rdy", tx_rdy, 1);
    dev_clk = 1'b1;
    cyc_wait(5);
    rst_n = 1'b1;
    cyc_wait(5);
    chk("t6_rdy_after_rst", tx_rdy, 1);
    s = done_cnt;
    send(8'hF4);
    dev_frame(1'b1, 0, dbits);
    wait_done(s, 500);
    chk("t6_bits", dbits, exp_frame(8'hF4));
    chk("t6_err", done_err, 0);
    chk("t6_inh_len", inh_len, INH);

    cyc_wait(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
